// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer with HI/LO: 32-step shift-add multiply or restoring divide, then sign fixup.
// Latency 34 cycles from accepted start to HI/LO commit; new requests and HI/LO reads are stalled while busy.
module mdu_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_kill,
    input  logic                  i_rd_hilo,
    input  logic                  i_sel_hi,
    output logic [DATA_WIDTH-1:0] o_hilo,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_busy,
    output logic                  o_stall_en,
    output logic                  o_done,
    output logic                  o_div_zero
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W-1:0]         opnd;     // multiplicand or divisor magnitude
    logic [W-1:0]         acc_hi;   // product high half / partial remainder
    logic [W-1:0]         acc_lo;   // multiplier shifting out / quotient shifting in
    logic                 neg_q;
    logic                 neg_r;
    logic                 is_mul;

    logic         op_mul, op_div, op_signed;
    logic [W-1:0] abs_a, abs_b;
    logic [W:0]   mul_sum;
    logic [W:0]   rem_sh, rem_diff;
    logic         rem_ge;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0] quo_fix, rem_fix;

    always_comb begin
        op_mul    = (i_op == 3'b000) || (i_op == 3'b001);
        op_div    = (i_op == 3'b010) || (i_op == 3'b011);
        op_signed = ~i_op[0];
        abs_a     = (op_signed && i_a[W-1]) ? -i_a : i_a;
        abs_b     = (op_signed && i_b[W-1]) ? -i_b : i_b;

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});

        rem_sh    = {acc_hi, acc_lo[W-1]};
        rem_diff  = rem_sh - {1'b0, opnd};
        rem_ge    = rem_sh >= {1'b0, opnd};

        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = neg_q ? -acc_lo : acc_lo;
        rem_fix   = neg_r ? -acc_hi : acc_hi;
    end

    assign o_busy     = (state != IDLE);
    assign o_stall_en = o_busy & (i_start | i_rd_hilo);
    assign o_hilo     = i_sel_hi ? o_hi : o_lo;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            opnd       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            is_mul     <= 1'b0;
            o_hi       <= '0;
            o_lo       <= '0;
            o_done     <= 1'b0;
            o_div_zero <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_div_zero <= 1'b0;
            if (i_kill) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            if (op_mul || (op_div && (i_b != '0))) begin
                                state  <= RUN;
                                cnt    <= '0;
                                acc_hi <= '0;
                                is_mul <= op_mul;
                                opnd   <= op_mul ? abs_a : abs_b;
                                acc_lo <= op_mul ? abs_b : abs_a;
                                neg_q  <= op_signed & (i_a[W-1] ^ i_b[W-1]);
                                neg_r  <= op_signed & i_a[W-1];
                            end else if (op_div) begin
                                o_div_zero <= 1'b1;
                            end else if (i_op == 3'b100) begin
                                o_hi <= i_a;
                            end else if (i_op == 3'b101) begin
                                o_lo <= i_a;
                            end
                        end
                    end
                    RUN: begin
                        if (is_mul) begin
                            acc_hi <= mul_sum[W:1];
                            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                        end else begin
                            acc_hi <= rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
                            acc_lo <= {acc_lo[W-2:0], rem_ge};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_WIDTH'(W-1)) state <= FIX;
                    end
                    FIX: begin
                        if (is_mul) begin
                            o_hi <= prod_fix[2*W-1:W];
                            o_lo <= prod_fix[W-1:0];
                        end else begin
                            o_hi <= rem_fix;
                            o_lo <= quo_fix;
                        end
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the iterative multiply/divide unit and the HI/LO register pair. It sits beside the execute stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from decode/execute. It runs a 32-step shift-add multiply or restoring divide, applies sign fixup, and commits to HI/LO. It drives a stall to the hazard logic whenever a new MDU op or an MFHI/MFLO read meets a busy unit.

## Interface
- DATA_WIDTH, 32, operand/HI/LO width
- CNT_WIDTH, log(2, DATA_WIDTH), iteration counter width
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous reset, active high (one clock; reset is synchronous and active-high)
- i_start  in  1  request valid this cycle
- i_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored
- i_a  in  DATA_WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- i_b  in  DATA_WIDTH  rt operand (divisor / multiplier)
- i_kill  in  1  interrupt/exception kill; aborts in-flight op
- i_rd_hilo  in  1  MFHI/MFLO in decode
- i_sel_hi  in  1  1 = read HI, 0 = read LO
- o_hilo  out  DATA_WIDTH  i_sel_hi ? HI : LO, combinational
- o_hi, o_lo  out  DATA_WIDTH  architectural HI/LO
- o_busy  out  1  unit in RUN or FIX
- o_stall_en  out  1  o_busy & (i_start | i_rd_hilo), combinational
- o_done  out  1  one-cycle pulse, HI/LO just committed by mult/div
- o_div_zero  out  1  one-cycle pulse, DIV/DIVU with i_b == 0 rejected

## Operation
- States: IDLE, RUN, FIX.
- IDLE, i_start, op MULT*/DIV*, b != 0 or MULT*:
  - latch |a|, |b|: abs for signed ops, raw for unsigned;
  - latch neg_q = a[31]^b[31] and neg_r = a[31] (signed only; 0 for unsigned);
  - clear accumulator and counter;
  - go to RUN.
- IDLE, i_start, DIV/DIVU with b == 0:
  - pulse o_div_zero next cycle; HI/LO unchanged;
  - stay IDLE; no o_done.
- IDLE, i_start, MTHI/MTLO: write i_a into HI/LO at this edge; stay IDLE; not busy.
- RUN, one iteration per cycle; counter 0..DATA_WIDTH-1; leave to FIX when counter == DATA_WIDTH-1.
  - Multiply: 2W accumulator {acc_hi, acc_lo}; add multiplicand to acc_hi if multiplier LSB set; shift right 1 with carry in.
  - Divide: restoring; shift {rem, quo} left 1; subtract divisor when rem >= divisor; set quotient bit.
- FIX, one cycle:
  - multiply: 2W product negated if neg_q;
  - divide: quotient negated if neg_q, remainder negated if neg_r;
  - commit HI = product[63:32] / remainder and LO = product[31:0] / quotient at end of FIX;
  - go IDLE.
- Working registers are separate from HI/LO; HI/LO change only on FIX commit, MTHI/MTLO, or reset.
- i_kill, any state: IDLE at next edge, no commit, no o_done. i_kill with i_start in IDLE: kill wins, request dropped (MTHI/MTLO also dropped).
- i_start while busy: ignored; o_stall_en holds decode until IDLE.
- Arithmetic is mod 2^W. DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0; no trap.

## Timing
- Reset: all outputs 0, HI = LO = 0, state IDLE, counter 0.
- Start accepted at edge T. RUN occupies cycles T+1..T+32; FIX is cycle T+33.
- HI/LO are new and o_done = 1 in cycle T+34. Issue to result is 34 cycles.
- o_busy = 1 in cycles T+1..T+33. A back-to-back start is accepted in cycle T+34.
- o_stall_en is asserted for an MFHI in cycle T+33. The read in T+34 sees committed data.
- MTHI/MTLO: new value visible on o_hilo in cycle T+1.
- o_div_zero is high in cycle T+1 only.
- i_rst mid-op takes priority over all inputs, including kill and start.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 -> cycle T+34: HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_done=1 for 1 cycle, o_busy high 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
- MTHI 0x12345678 then DIVU a=5, b=0 -> o_div_zero pulse at T+1, HI stays 0x12345678, no o_done, o_busy never set.
- MULT started, i_kill at T+10 -> IDLE at T+11, HI/LO unchanged, no o_done; new MULT accepted at T+11.
- DIV in flight, i_rd_hilo=1 from T+5 -> o_stall_en=1 through T+33, 0 at T+34 with o_hilo = committed value; i_rst at T+20 -> all outputs 0 next cycle.
